// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with branch resolution, a one-cycle redirect pulse and a saturating taken-branch counter.
// Optional macro EX_BRANCH_SIGN_EN adds BLTZ/BGEZ resolution from the ALU sign flag.
module ex_mem_reg #(
  parameter int NB_A   = 32,
  parameter int NB_REG = 5,
  parameter int NB_CNT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NB_A-1:0]   x,
  input  logic              flag_zero,
  input  logic              signo,
  input  logic [NB_A-1:0]   store_data,
  input  logic [NB_REG-1:0] rd_addr,
  input  logic [NB_A-1:0]   branch_target,
  input  logic              valid_in,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              branch_eq,
  input  logic              branch_ne,
  input  logic              branch_ltz,
  input  logic              branch_gez,
  input  logic              stall,
  input  logic              flush,
  output logic [NB_A-1:0]   o_x,
  output logic [NB_A-1:0]   o_store_data,
  output logic [NB_REG-1:0] o_rd_addr,
  output logic              o_reg_write,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_mem_to_reg,
  output logic              o_valid,
  output logic              pc_src,
  output logic [NB_A-1:0]   pc_target,
  output logic [NB_CNT-1:0] taken_count
);

  localparam logic [NB_CNT-1:0] CNT_MAX = '1;
  localparam logic [NB_CNT-1:0] CNT_ONE = NB_CNT'(1);

  logic cond_take;
  logic take;

  // Both eq and ne set (illegal decode) always resolves taken, since one flag term is true.
  always_comb begin
    cond_take = (branch_eq & flag_zero) | (branch_ne & ~flag_zero);
`ifdef EX_BRANCH_SIGN_EN
    cond_take = cond_take | (branch_ltz & signo) | (branch_gez & ~signo);
`endif
  end

`ifndef EX_BRANCH_SIGN_EN
  // Sign-branch inputs stay on the port list so instantiations match both builds.
  logic unused_sign_in;
  assign unused_sign_in = &{1'b0, branch_ltz, branch_gez, signo};
`endif

  assign take = valid_in & ~stall & ~flush & cond_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_x          <= '0;
      o_store_data <= '0;
      o_rd_addr    <= '0;
      o_reg_write  <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_valid      <= 1'b0;
      pc_src       <= 1'b0;
      pc_target    <= '0;
      taken_count  <= '0;
    end else begin
      // take already excludes stall and flush, so the pulse never repeats.
      pc_src <= take;
      if (take) begin
        pc_target <= branch_target;
        if (taken_count != CNT_MAX)
          taken_count <= taken_count + CNT_ONE;
      end

      if (flush) begin
        o_x          <= '0;
        o_store_data <= '0;
        o_rd_addr    <= '0;
        o_reg_write  <= 1'b0;
        o_mem_read   <= 1'b0;
        o_mem_write  <= 1'b0;
        o_mem_to_reg <= 1'b0;
        o_valid      <= 1'b0;
      end else if (!stall) begin
        o_x          <= x;
        o_store_data <= store_data;
        o_rd_addr    <= rd_addr;
        o_reg_write  <= reg_write  & valid_in;
        o_mem_read   <= mem_read   & valid_in;
        o_mem_write  <= mem_write  & valid_in;
        o_mem_to_reg <= mem_to_reg & valid_in;
        o_valid      <= valid_in;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed-vector bench for ex_mem_reg (counter width 4 so saturation is reachable quickly).
module tb_ex_mem_reg;

  logic        clk;
  logic        rst_n;
  logic [31:0] x;
  logic        flag_zero;
  logic        signo;
  logic [31:0] store_data;
  logic [4:0]  rd_addr;
  logic [31:0] branch_target;
  logic        valid_in;
  logic        reg_write, mem_read, mem_write, mem_to_reg;
  logic        branch_eq, branch_ne, branch_ltz, branch_gez;
  logic        stall, flush;
  logic [31:0] o_x, o_store_data;
  logic [4:0]  o_rd_addr;
  logic        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg;
  logic        o_valid, pc_src;
  logic [31:0] pc_target;
  logic [3:0]  taken_count;

  int errors = 0;
  int checks = 0;

`ifdef EX_BRANCH_SIGN_EN
  localparam int SIGN_EN = 1;
`else
  localparam int SIGN_EN = 0;
`endif

  ex_mem_reg #(.NB_A(32), .NB_REG(5), .NB_CNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .flag_zero(flag_zero), .signo(signo),
    .store_data(store_data), .rd_addr(rd_addr), .branch_target(branch_target),
    .valid_in(valid_in), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .branch_eq(branch_eq),
    .branch_ne(branch_ne), .branch_ltz(branch_ltz), .branch_gez(branch_gez),
    .stall(stall), .flush(flush), .o_x(o_x), .o_store_data(o_store_data),
    .o_rd_addr(o_rd_addr), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg), .o_valid(o_valid),
    .pc_src(pc_src), .pc_target(pc_target), .taken_count(taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock per transaction; outputs are sampled 1 time unit after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    $display("[%0t] %s: o_x=%0h o_valid=%0b pc_src=%0b pc_target=%0h taken_count=%0d",
             $time, tag, o_x, o_valid, pc_src, pc_target, taken_count);
  endtask

  task automatic clear_branch();
    branch_eq = 0; branch_ne = 0; branch_ltz = 0; branch_gez = 0;
  endtask

  initial begin
    rst_n = 0; x = 0; flag_zero = 0; signo = 0; store_data = 0; rd_addr = 0;
    branch_target = 0; valid_in = 0; reg_write = 0; mem_read = 0; mem_write = 0;
    mem_to_reg = 0; stall = 0; flush = 0;
    clear_branch();

    #2;
    check("reset_o_x", o_x, 32'h0);
    check("reset_o_valid", {31'b0, o_valid}, 32'h0);
    check("reset_pc_src", {31'b0, pc_src}, 32'h0);
    check("reset_pc_target", pc_target, 32'h0);
    check("reset_count", {28'b0, taken_count}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1;

    // Plain capture
    x = 32'h100; rd_addr = 5'd8; reg_write = 1; valid_in = 1; store_data = 32'hDEAD;
    step("capture");
    check("cap_o_x", o_x, 32'h100);
    check("cap_rd", {27'b0, o_rd_addr}, 32'd8);
    check("cap_reg_write", {31'b0, o_reg_write}, 32'h1);
    check("cap_valid", {31'b0, o_valid}, 32'h1);
    check("cap_store", o_store_data, 32'hDEAD);
    check("cap_pc_src", {31'b0, pc_src}, 32'h0);

    // Bubble: control squashed, data still captured
    x = 32'h55; valid_in = 0; reg_write = 1; mem_write = 1;
    step("bubble");
    check("bub_valid", {31'b0, o_valid}, 32'h0);
    check("bub_reg_write", {31'b0, o_reg_write}, 32'h0);
    check("bub_mem_write", {31'b0, o_mem_write}, 32'h0);
    check("bub_o_x", o_x, 32'h55);
    reg_write = 0; mem_write = 0;

    // BEQ taken, then pulse must drop
    valid_in = 1; branch_eq = 1; flag_zero = 1; branch_target = 32'h40;
    step("beq_taken");
    check("beq_pc_src", {31'b0, pc_src}, 32'h1);
    check("beq_target", pc_target, 32'h40);
    check("beq_count", {28'b0, taken_count}, 32'd1);
    clear_branch();
    step("after_beq");
    check("beq_pulse_end", {31'b0, pc_src}, 32'h0);
    check("beq_target_hold", pc_target, 32'h40);

    // BEQ not taken
    branch_eq = 1; flag_zero = 0; branch_target = 32'h80;
    step("beq_not_taken");
    check("beqnt_pc_src", {31'b0, pc_src}, 32'h0);
    check("beqnt_target", pc_target, 32'h40);
    check("beqnt_count", {28'b0, taken_count}, 32'd1);
    clear_branch();

    // BNE taken, then illegal eq+ne with zero flag set
    branch_ne = 1; flag_zero = 0; branch_target = 32'h120;
    step("bne_taken");
    check("bne_pc_src", {31'b0, pc_src}, 32'h1);
    check("bne_target", pc_target, 32'h120);
    check("bne_count", {28'b0, taken_count}, 32'd2);
    branch_eq = 1; branch_ne = 1; flag_zero = 1; branch_target = 32'h200;
    step("eq_ne_both");
    check("both_pc_src", {31'b0, pc_src}, 32'h1);
    check("both_target", pc_target, 32'h200);
    check("both_count", {28'b0, taken_count}, 32'd3);

    // Branch with valid_in low never redirects
    clear_branch(); branch_eq = 1; flag_zero = 1; valid_in = 0; branch_target = 32'h240;
    step("invalid_branch");
    check("inv_pc_src", {31'b0, pc_src}, 32'h0);
    check("inv_count", {28'b0, taken_count}, 32'd3);
    clear_branch();

    // Stall holds data; a taken BNE during stall is suppressed
    x = 32'hA5; valid_in = 1; reg_write = 1; mem_read = 1;
    step("capture_a5");
    check("a5_o_x", o_x, 32'hA5);
    stall = 1; branch_ne = 1; flag_zero = 0; branch_target = 32'h300;
    for (int i = 0; i < 3; i++) begin
      x = 32'h1000 + i;
      step("stall");
      check("stall_o_x", o_x, 32'hA5);
      check("stall_mem_read", {31'b0, o_mem_read}, 32'h1);
      check("stall_pc_src", {31'b0, pc_src}, 32'h0);
    end
    check("stall_count", {28'b0, taken_count}, 32'd3);
    check("stall_target", pc_target, 32'h200);

    // Flush wins over stall
    flush = 1;
    step("flush_stall");
    check("flush_valid", {31'b0, o_valid}, 32'h0);
    check("flush_reg_write", {31'b0, o_reg_write}, 32'h0);
    check("flush_mem_read", {31'b0, o_mem_read}, 32'h0);
    check("flush_o_x", o_x, 32'h0);
    check("flush_pc_src", {31'b0, pc_src}, 32'h0);
    check("flush_count", {28'b0, taken_count}, 32'd3);
    flush = 0; stall = 0; reg_write = 0; mem_read = 0;
    clear_branch();

    // Sign branches: only redirect when the optional feature is built in
    branch_ltz = 1; signo = 1; flag_zero = 0; branch_target = 32'h400;
    step("bltz");
    check("bltz_pc_src", {31'b0, pc_src}, 32'(SIGN_EN));
    check("bltz_count", {28'b0, taken_count}, 32'(3 + SIGN_EN));
    clear_branch();
    branch_gez = 1; signo = 0; flag_zero = 1; branch_target = 32'h440;
    step("bgez_zero");
    check("bgez_pc_src", {31'b0, pc_src}, 32'(SIGN_EN));
    check("bgez_count", {28'b0, taken_count}, 32'(3 + 2 * SIGN_EN));
    clear_branch();

    // Reset while pc_src is high
    branch_eq = 1; flag_zero = 1; branch_target = 32'h500;
    step("beq_before_reset");
    check("prerst_pc_src", {31'b0, pc_src}, 32'h1);
    #2;
    rst_n = 0;
    #1;
    check("rst_pc_src", {31'b0, pc_src}, 32'h0);
    check("rst_valid", {31'b0, o_valid}, 32'h0);
    check("rst_count", {28'b0, taken_count}, 32'h0);
    clear_branch();
    @(posedge clk); #1;
    rst_n = 1;

    // 20 consecutive taken branches saturate the 4-bit counter
    valid_in = 1; branch_eq = 1; flag_zero = 1; branch_target = 32'h600;
    for (int i = 0; i < 20; i++) begin
      step("sat_branch");
      check("sat_count", {28'b0, taken_count}, (i < 15) ? 32'(i + 1) : 32'd15);
      check("sat_pc_src", {31'b0, pc_src}, 32'h1);
    end
    clear_branch();
    step("sat_idle");
    check("sat_hold", {28'b0, taken_count}, 32'd15);
    check("sat_pc_src_end", {31'b0, pc_src}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
